// File: rtl/fir_mac_sequencer.sv
// FIR read-side sequencer: accepts a sample, shifts it into the delay line,
// sweeps all taps through a MAC, and emits one saturated Q1.15 result.
module fir_mac_sequencer #(
  parameter int LENGTH = 64,
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 2*WIDTH + $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             load,
  output logic [WIDTH-1:0] sample_out,
  output logic [7:0]       counter,
  input  logic [WIDTH-1:0] tap_in,
  input  logic [WIDTH-1:0] coef_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(LENGTH - 1);
  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'(2**(WIDTH-1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  state_t state, state_nx;

  logic signed [2*WIDTH-1:0] tap_x, coef_x;
  logic signed [2*WIDTH-1:0] prod, prod_nx;
  logic                      prod_valid;
  logic signed [ACC_W-1:0]   acc, prod_ext;
  logic signed [ACC_W-1:0]   final_sum, shifted;
  logic [WIDTH-1:0]          sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = LOAD;
      LOAD:  state_nx = MAC;
      MAC:   if (counter == LAST) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign load     = (state == LOAD);

  assign tap_x   = {{WIDTH{tap_in[WIDTH-1]}}, tap_in};
  assign coef_x  = {{WIDTH{coef_in[WIDTH-1]}}, coef_in};
  assign prod_nx = tap_x * coef_x;

  assign prod_ext =
    {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign final_sum = acc + prod_ext;
  assign shifted   = final_sum >>> (WIDTH-1);

  // Truncating shift first, then clamp to the Q1.(WIDTH-1) range.
  always_comb begin
    sat = shifted[WIDTH-1:0];
    if (shifted > MAXV)
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < MINV)
      sat = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      counter    <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) sample_out <= in_data;
        end
        LOAD: begin
          acc        <= '0;
          prod_valid <= 1'b0;
          counter    <= '0;
        end
        MAC: begin
          prod       <= prod_nx;
          prod_valid <= 1'b1;
          if (prod_valid) acc <= acc + prod_ext;
          if (counter == LAST) counter <= '0;
          else                 counter <= counter + 8'd1;
        end
        DRAIN: begin
          out_data  <= sat;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Read-side controller for the FIR sample delay line. Accepts one input sample per valid/ready handshake and pulses the delay line's `load` to shift the sample in. It then sweeps the tap `counter` over all LENGTH taps, multiplying each tap by the matching coefficient and accumulating. It emits one saturated Q1.15 filter output per input sample on a valid/ready output port.

## Interface
- `LENGTH`, 64: number of taps; the counter sweeps 0..LENGTH-1; must be ≤ 256.
- `WIDTH`, 16: signed sample and coefficient width (Q1.(WIDTH-1)).
- `ACC_W`, 2*WIDTH + $clog2(LENGTH) (38 by default): accumulator width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample available.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  WIDTH  signed input sample.
- `load`  out  1  shift strobe to the delay line.
- `sample_out`  out  WIDTH  sample driven to the delay line input.
- `counter`  out  8  tap index to the delay line read port and coefficient ROM.
- `tap_in`  in  WIDTH  signed tap value from the delay line, combinational from `counter`.
- `coef_in`  in  WIDTH  signed coefficient for `counter`, combinational.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  signed saturated filter output.

## Operation
- The FSM has five states: IDLE, LOAD, MAC, DRAIN, DONE.
- **IDLE**
  - `in_ready` = 1 (combinational decode of IDLE).
  - On `in_valid & in_ready`, capture `in_data` into the sample register and go to LOAD.
- **LOAD** (one cycle)
  - `load` = 1 and `sample_out` = captured sample.
  - Clear the accumulator and `prod_valid`; set `counter` = 0.
  - Go to MAC.
- **MAC** (LENGTH cycles, `counter` = k for k = 0..LENGTH-1)
  - `prod` <= `tap_in` * `coef_in` (signed, 2*WIDTH bits); `prod_valid` <= 1.
  - If `prod_valid`, acc <= acc + sign-extended `prod`.
  - `counter` increments each cycle. At k = LENGTH-1, go to DRAIN with `counter` <= 0.
- **DRAIN** (one cycle)
  - final = acc + `prod`.
  - `out_data` <= sat(final >>> (WIDTH-1)); `out_valid` <= 1. Go to DONE.
- **DONE**
  - Hold `out_valid` and `out_data` stable until `out_ready`.
  - On handshake, clear `out_valid` and go to IDLE.
  - `in_valid` is ignored in DONE; a new sample is never accepted in the same cycle as the output handshake.
- **Arithmetic**
  - Arithmetic right shift (truncation, no rounding).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]: 0x8000..0x7FFF at the default width.
  - The accumulator never wraps at ACC_W.
- **Defaults**
  - `load` = 0 and `sample_out` holds its last value outside LOAD.
  - `counter` = 0 outside MAC.
- **Reset**
  - Asserting `rst` in any state, including mid-MAC, forces IDLE.
  - Clears: acc = 0, `prod` = 0, `prod_valid` = 0, `counter` = 0, `load` = 0, `sample_out` = 0, `out_valid` = 0, `out_data` = 0.
  - No partial result is emitted, and the next sample computes from a clean accumulator.

## Timing
- Reset values: `in_ready` = 1 (state IDLE); all other outputs 0.
- For an input handshake at edge T:
  - LOAD during cycle T+1.
  - MAC during T+2..T+LENGTH+1.
  - DRAIN during T+LENGTH+2.
  - `out_valid` = 1 from T+LENGTH+3 (T+67 at the default LENGTH).
- `in_ready` is 0 from T+1 until the cycle after the output handshake.
- Minimum sample period is LENGTH+4 cycles, with `out_ready` held high.
- The delay line has shifted by the first MAC cycle, so `counter` = 0 reads the newest sample.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle.
  - Immediately: `out_valid` = 0, `load` = 0, `counter` = 0, `out_data` = 0x0000.
  - After release: `in_ready` = 1.
- **Single-tap impulse:** tap0 = 0x4000, all other taps 0, coef0 = 0x4000 -> `out_data` = 0x2000.
- **Saturation:**
  - All taps 0x2000, all coefs 0x4000 -> 0x7FFF.
  - All taps 0x8000, all coefs 0x7FFF -> 0x8000.
- **Cycle check:** `in_valid` = 1 with `in_data` = 0x1234, handshake at edge T.
  - `load` is high only in cycle T+1, with `sample_out` = 0x1234.
  - `counter` runs 0..63 over T+2..T+65.
  - `out_valid` rises at T+67.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles while `in_valid` = 1.
  - `out_data` stays stable, `in_ready` stays 0, and no `load` occurs.
  - After `out_ready` = 1, IDLE is reached the next cycle and the pending sample is accepted.
- **Reset mid-MAC:** assert `rst` at `counter` = 30.
  - Next cycle: IDLE with `out_valid` = 0.
  - The following impulse sample from the single-tap test still yields exactly 0x2000.
